store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 197 +++++++++++++++++++
 tb/tb_store_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//
// MEM-stage store engine. Encodes byte-lane enables and lane-positioned write
// data for SB/SH/SW/SWL/SWR, issues one bus write and holds the pipeline
// until the bus acknowledges it. It also flags misaligned stores (address
// error) and ack timeouts (bus error).
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   st_req      MEM stage presents a store this cycle
//   aluop       operation code (store codes ALU_SB..ALU_SWR)
//   addr        byte address of the store
//   opr2        rt register data
//   flush       pipeline flush (only affects requests not yet accepted)
//   dbus_req    bus write request
//   dbus_addr   word-aligned bus address
//   dbus_wen    byte-lane write enables, 0 whenever dbus_req is 0
//   dbus_wdata  lane-positioned write data
//   dbus_ack    bus accepts the write (only looked at while waiting)
//   stallreq    pipeline stall request
//   st_done     one-cycle pulse when a store completes
//   st_adel     one-cycle pulse on a misaligned store
//   st_buserr   one-cycle pulse on ack timeout
// -----------------------------------------------------------------------------
package store_unit_pkg;
    typedef enum logic [4:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_LW,
        ALU_SB,
        ALU_SH,
        ALU_SW,
        ALU_SWL,
        ALU_SWR
    } alu_op_t;
endpackage

module store_unit
    import store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_req,
    input  alu_op_t     aluop,
    input  logic [31:0] addr,
    input  logic [31:0] opr2,
    input  logic        flush,
    output logic        dbus_req,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wen,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    output logic        stallreq,
    output logic        st_done,
    output logic        st_adel,
    output logic        st_buserr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // The counter starts at 0 in the first WAIT cycle, so the last permitted
    // WAIT cycle is the one where it holds TIMEOUT-1; leaving on that edge
    // gives exactly TIMEOUT cycles of dbus_req.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;

    logic        is_store;
    logic        misaligned;
    logic [3:0]  enc_wen;
    logic [31:0] enc_wdata;
    logic        accept;
    logic        adel_hit;

    // Lane encoding of the presented store.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        is_store   = 1'b0;
        misaligned = 1'b0;
        enc_wen    = 4'b0000;
        enc_wdata  = 32'h0;
        unique case (aluop)
            ALU_SB: begin
                is_store  = 1'b1;
                enc_wen   = 4'b0001 << addr[1:0];
                enc_wdata = {4{opr2[7:0]}};
            end
            ALU_SH: begin
                is_store   = 1'b1;
                misaligned = addr[0];
                enc_wen    = addr[1] ? 4'b1100 : 4'b0011;
                enc_wdata  = {2{opr2[15:0]}};
            end
            ALU_SW: begin
                is_store   = 1'b1;
                misaligned = (addr[1:0] != 2'b00);
                enc_wen    = 4'b1111;
                enc_wdata  = opr2;
            end
            ALU_SWL: begin
                is_store = 1'b1;
                unique case (addr[1:0])
                    2'b00: begin enc_wen = 4'b0001; enc_wdata = {24'h0, opr2[31:24]}; end
                    2'b01: begin enc_wen = 4'b0011; enc_wdata = {16'h0, opr2[31:16]}; end
                    2'b10: begin enc_wen = 4'b0111; enc_wdata = {8'h0,  opr2[31:8]};  end
                    default: begin enc_wen = 4'b1111; enc_wdata = opr2; end
                endcase
            end
            ALU_SWR: begin
                is_store = 1'b1;
                unique case (addr[1:0])
                    2'b00: begin enc_wen = 4'b1111; enc_wdata = opr2; end
                    2'b01: begin enc_wen = 4'b1110; enc_wdata = {opr2[23:0], 8'h0};  end
                    2'b10: begin enc_wen = 4'b1100; enc_wdata = {opr2[15:0], 16'h0}; end
                    default: begin enc_wen = 4'b1000; enc_wdata = {opr2[7:0], 24'h0}; end
                endcase
            end
            default: ;
        endcase
    end

    // Requests are only considered in IDLE; anything presented while a write
    // is in flight or in RESP is left for the pipeline to re-present.
    assign accept   = (state == S_IDLE) && st_req && is_store && !flush && !misaligned;
    assign adel_hit = (state == S_IDLE) && st_req && is_store && !flush &&  misaligned;

    assign stallreq = accept || (state == S_WAIT) || (state == S_RESP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 8'h0;
            dbus_req   <= 1'b0;
            dbus_addr  <= 32'h0;
            dbus_wen   <= 4'b0000;
            dbus_wdata <= 32'h0;
            st_done    <= 1'b0;
            st_adel    <= 1'b0;
            st_buserr  <= 1'b0;
        end else begin
            st_done   <= 1'b0;
            st_adel   <= 1'b0;
            st_buserr <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_WAIT;
                        wait_cnt   <= 8'h0;
                        dbus_req   <= 1'b1;
                        dbus_addr  <= {addr[31:2], 2'b00};
                        dbus_wen   <= enc_wen;
                        dbus_wdata <= enc_wdata;
                    end else if (adel_hit) begin
                        st_adel <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Ack is tested first so it wins over a simultaneous timeout.
                    // flush is deliberately not looked at: the write is committed.
                    if (dbus_ack) begin
                        state    <= S_RESP;
                        dbus_req <= 1'b0;
                        dbus_wen <= 4'b0000;
                        st_done  <= 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= S_IDLE;
                        wait_cnt  <= 8'h0;
                        dbus_req  <= 1'b0;
                        dbus_wen  <= 4'b0000;
                        st_buserr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    dbus_req <= 1'b0;
                    dbus_wen <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//
// Self-checking bench for store_unit (TIMEOUT=4). Inputs are driven and
// outputs sampled on the falling clock edge; the expected lane encoding comes
// from an arithmetic reference model of the store rules.
// -----------------------------------------------------------------------------
module tb_store_unit;
    import store_unit_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        st_req;
    alu_op_t     aluop;
    logic [31:0] addr;
    logic [31:0] opr2;
    logic        flush;
    logic        dbus_req;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wen;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic        stallreq;
    logic        st_done;
    logic        st_adel;
    logic        st_buserr;

    int checks = 0;
    int errors = 0;

    store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_req     (st_req),
        .aluop      (aluop),
        .addr       (addr),
        .opr2       (opr2),
        .flush      (flush),
        .dbus_req   (dbus_req),
        .dbus_addr  (dbus_addr),
        .dbus_wen   (dbus_wen),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .stallreq   (stallreq),
        .st_done    (st_done),
        .st_adel    (st_adel),
        .st_buserr  (st_buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // Full view: {req, addr, wen, wdata, stall, done, adel, buserr}.
    function automatic logic [72:0] obs_full();
        return {dbus_req, dbus_addr, dbus_wen, dbus_wdata, stallreq, st_done, st_adel, st_buserr};
    endfunction

    // Control view: {req, wen, stall, done, adel, buserr}.
    function automatic logic [8:0] obs_ctl();
        return {dbus_req, dbus_wen, stallreq, st_done, st_adel, st_buserr};
    endfunction

    // Reference model: lane enables/data derived from byte offsets arithmetically.
    function automatic void ref_enc(input alu_op_t op, input logic [31:0] a, input logic [31:0] d,
                                    output logic [3:0] wen, output logic [31:0] wd, output logic mis);
        int off;
        off = int'(a[1:0]);
        wen = 4'b0000;
        wd  = 32'h0;
        mis = 1'b0;
        case (op)
            ALU_SB:  begin wen = 4'(1 << off); wd = {4{d[7:0]}}; end
            ALU_SH:  begin wen = 4'(3 << off); wd = {2{d[15:0]}}; mis = (off % 2) != 0; end
            ALU_SW:  begin wen = 4'hF; wd = d; mis = (off != 0); end
            ALU_SWL: begin wen = 4'((1 << (off + 1)) - 1); wd = d >> (8 * (3 - off)); end
            ALU_SWR: begin wen = 4'((15 << off) & 15); wd = d << (8 * off); end
            default: ;
        endcase
    endfunction

    task automatic idle_inputs();
        st_req   = 1'b0;
        aluop    = ALU_NOP;
        addr     = 32'h0;
        opr2     = 32'h0;
        flush    = 1'b0;
        dbus_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #3;
        checks++;
        if (obs_full() !== 73'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required %h", obs_full(), 73'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_full() !== 73'h0) begin
            errors++;
            $display("FAIL reset_release: got %h, required %h", obs_full(), 73'h0);
        end
    endtask

    // One store from presentation to return to IDLE. ack_at = WAIT cycle
    // (1-based) carrying dbus_ack, 0 = never ack. flush_at = WAIT cycle with flush.
    task automatic run_store(input string name, input alu_op_t op, input logic [31:0] a,
                             input logic [31:0] d, input int ack_at, input int flush_at);
        logic [3:0]  wen;
        logic [31:0] wd;
        logic        mis;
        logic [31:0] wa;
        int          n_wait;
        ref_enc(op, a, d, wen, wd, mis);
        wa = {a[31:2], 2'b00};

        @(negedge clk);
        st_req = 1'b1; aluop = op; addr = a; opr2 = d; flush = 1'b0; dbus_ack = 1'b0;
        #1;
        checks++;
        if (obs_ctl() !== {1'b0, 4'b0000, !mis, 3'b000}) begin
            errors++;
            $display("FAIL %s present: got %b, required %b", name, obs_ctl(), {1'b0, 4'b0000, !mis, 3'b000});
        end

        @(negedge clk);
        // Scramble the request inputs: the bus fields must come from the latch.
        st_req = 1'b0; aluop = ALU_NOP; addr = $urandom; opr2 = $urandom;

        if (mis) begin
            checks++;
            if (obs_ctl() !== 9'b0_0000_0010) begin
                errors++;
                $display("FAIL %s adel: got %b, required %b", name, obs_ctl(), 9'b0_0000_0010);
            end
            @(negedge clk);
            checks++;
            if (obs_ctl() !== 9'b0) begin
                errors++;
                $display("FAIL %s adel_once: got %b, required %b", name, obs_ctl(), 9'b0);
            end
            return;
        end

        n_wait = (ack_at == 0) ? TO : ack_at;
        for (int w = 1; w <= n_wait; w++) begin
            checks++;
            if (obs_full() !== {1'b1, wa, wen, wd, 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL %s wait%0d: got %h, required %h", name, w, obs_full(),
                         {1'b1, wa, wen, wd, 1'b1, 3'b000});
            end
            flush    = (w == flush_at);
            dbus_ack = (w == ack_at);
            @(negedge clk);
        end
        flush = 1'b0; dbus_ack = 1'b0;

        if (ack_at != 0) begin
            checks++;
            if (obs_ctl() !== 9'b0_0000_1100) begin
                errors++;
                $display("FAIL %s resp: got %b, required %b", name, obs_ctl(), 9'b0_0000_1100);
            end
        end else begin
            checks++;
            if (obs_ctl() !== 9'b0_0000_0001) begin
                errors++;
                $display("FAIL %s buserr: got %b, required %b", name, obs_ctl(), 9'b0_0000_0001);
            end
        end
        @(negedge clk);
        checks++;
        if (obs_ctl() !== 9'b0) begin
            errors++;
            $display("FAIL %s back_idle: got %b, required %b", name, obs_ctl(), 9'b0);
        end
    endtask

    task automatic test_directed();
        run_store("sb_1003",  ALU_SB,  32'h0000_1003, 32'hAABB_CCDD, 3, 0);
        run_store("swl_a01",  ALU_SWL, 32'h0000_3001, 32'h1122_3344, 1, 0);
        run_store("swr_a10",  ALU_SWR, 32'h0000_3002, 32'h1122_3344, 2, 0);
        run_store("sh_2001",  ALU_SH,  32'h0000_2001, 32'h1234_5678, 1, 0);
        run_store("sw_2002",  ALU_SW,  32'h0000_2002, 32'h1234_5678, 1, 0);
        run_store("sh_2002",  ALU_SH,  32'h0000_2002, 32'hCAFE_BEEF, 1, 0);
    endtask

    task automatic test_timeout();
        run_store("sw_timeout",  ALU_SW, 32'h0000_4000, 32'hDEAD_BEEF, 0, 0);
        run_store("ack_at_last", ALU_SW, 32'h0000_4004, 32'h0BAD_F00D, TO, 0);
    endtask

    task automatic test_flush();
        run_store("flush_wait", ALU_SW, 32'h0000_5000, 32'h5555_AAAA, 3, 1);
    endtask

    task automatic test_ignored();
        @(negedge clk);
        st_req = 1'b1; aluop = ALU_ADD; addr = 32'h10; opr2 = 32'h1; flush = 1'b0;
        dbus_ack = 1'b1;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL nonstore_stall: got %b, required 0", stallreq);
        end
        @(negedge clk);
        aluop = ALU_SW; flush = 1'b1;
        #1;
        checks++;
        if (obs_ctl() !== 9'b0) begin
            errors++;
            $display("FAIL nonstore_ignored: got %b, required %b", obs_ctl(), 9'b0);
        end
        @(negedge clk);
        aluop = ALU_SH; addr = 32'h11;
        #1;
        checks++;
        if (obs_ctl() !== 9'b0) begin
            errors++;
            $display("FAIL flush_ignored: got %b, required %b", obs_ctl(), 9'b0);
        end
        @(negedge clk);
        checks++;
        if (obs_ctl() !== 9'b0) begin
            errors++;
            $display("FAIL flush_misaligned_ignored: got %b, required %b", obs_ctl(), 9'b0);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        st_req = 1'b1; aluop = ALU_SW; addr = 32'h0000_6000; opr2 = 32'h1357_9BDF;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (dbus_req !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_req: got %b, required 1", dbus_req);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs_full() !== 73'h0) begin
            errors++;
            $display("FAIL rstwait_async: got %h, required %h", obs_full(), 73'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        dbus_ack = 1'b1;
        for (int i = 0; i < TO + 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl() !== 9'b0) begin
                errors++;
                $display("FAIL rstwait_quiet%0d: got %b, required %b", i, obs_ctl(), 9'b0);
            end
        end
        dbus_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  wen_b;
        logic [31:0] wd_b;
        logic        mis_b;
        logic [31:0] ab;
        logic [31:0] db;
        ab = 32'h0000_7008;
        db = 32'hFEED_FACE;
        ref_enc(ALU_SW, ab, db, wen_b, wd_b, mis_b);

        @(negedge clk);
        st_req = 1'b1; aluop = ALU_SW; addr = 32'h0000_7000; opr2 = 32'h0102_0304;
        @(negedge clk);
        // First WAIT cycle: ack A while B is already being presented.
        addr = ab; opr2 = db; dbus_ack = 1'b1;
        #1;
        checks++;
        if (obs_full() !== {1'b1, 32'h0000_7000, 4'hF, 32'h0102_0304, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL b2b_wait_a: got %h, required %h", obs_full(),
                     {1'b1, 32'h0000_7000, 4'hF, 32'h0102_0304, 1'b1, 3'b000});
        end
        @(negedge clk);
        dbus_ack = 1'b0;
        #1;
        checks++;
        if (obs_ctl() !== 9'b0_0000_1100) begin
            errors++;
            $display("FAIL b2b_resp_no_issue: got %b, required %b", obs_ctl(), 9'b0_0000_1100);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs_ctl() !== 9'b0_0000_1000) begin
            errors++;
            $display("FAIL b2b_idle_accept: got %b, required %b", obs_ctl(), 9'b0_0000_1000);
        end
        @(negedge clk);
        st_req = 1'b0; aluop = ALU_NOP;
        for (int w = 1; w <= 2; w++) begin
            checks++;
            if (obs_full() !== {1'b1, ab, wen_b, wd_b, 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL b2b_wait_b%0d: got %h, required %h", w, obs_full(),
                         {1'b1, ab, wen_b, wd_b, 1'b1, 3'b000});
            end
            dbus_ack = (w == 2);
            @(negedge clk);
        end
        dbus_ack = 1'b0;
        checks++;
        if (obs_ctl() !== 9'b0_0000_1100) begin
            errors++;
            $display("FAIL b2b_resp_b: got %b, required %b", obs_ctl(), 9'b0_0000_1100);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        alu_op_t ops [5];
        ops = '{ALU_SB, ALU_SH, ALU_SW, ALU_SWL, ALU_SWR};
        for (int i = 0; i < 60; i++) begin
            run_store($sformatf("rnd%0d", i), ops[$urandom_range(0, 4)], $urandom, $urandom,
                      int'($urandom_range(0, TO)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_flush();
        test_ignored();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
